mmu_rr_arbiter: RTL

//  Round-robin arbiter sharing one MMU resource (table-walk/bus port) among N requesters.

---
 rtl/mmu_rr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mmu_rr_arbiter.sv
// Round-robin arbiter for one shared MMU resource; registered one-hot grant held until done or withdraw.
// Optional watchdog release is compiled in when ARB_TIMEOUT_EN is defined.
module mmu_rr_arbiter #(
  parameter int N              = 4,
  parameter int IDXW           = $clog2(N),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            rsrc_done,
  output logic [N-1:0]    grant_onehot,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic            timeout
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    grant_reg, grant_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic [IDXW-1:0] ptr_adv;
  logic [IDXW-1:0] win_idx;
  logic            owner_req;
  logic            expire;
  logic            rel;

  // Requests viewed in priority order: position gi is requester (ptr + gi) mod N.
  logic [IDXW:0]   rot_sum [N];
  logic [IDXW-1:0] rot_idx [N];
  logic [N-1:0]    rot_req;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot_sum[gi] = {1'b0, ptr_reg} + (IDXW+1)'(gi);
    assign rot_idx[gi] = (rot_sum[gi] >= (IDXW+1)'(N)) ?
                         IDXW'(rot_sum[gi] - (IDXW+1)'(N)) : rot_sum[gi][IDXW-1:0];
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  always_comb begin
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_req[i]) win_idx = rot_idx[i];
    end
  end

  assign owner_req = req[idx_reg];
  assign ptr_adv   = (idx_reg == IDXW'(N - 1)) ? '0 : idx_reg + 1'b1;
  assign rel       = (state_reg == OWN) && (rsrc_done || !owner_req || expire);

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);

  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            timeout_reg;

  // Done or withdraw in the expiry cycle takes precedence, so no timeout pulse then.
  assign expire   = (state_reg == OWN) && !rsrc_done && owner_req &&
                    (cnt_reg == CNTW'(TIMEOUT_CYCLES - 1));
  assign cnt_next = (state_reg == OWN && !rel) ? cnt_reg + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= expire;
    end
  end

  assign timeout = timeout_reg;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next          = OWN;
          grant_next          = '0;
          grant_next[win_idx] = 1'b1;
          idx_next            = win_idx;
        end
      end
      OWN: begin
        // Releasing through IDLE guarantees an all-zero turnaround cycle between owners.
        if (rel) begin
          state_next = IDLE;
          grant_next = '0;
          idx_next   = '0;
          ptr_next   = ptr_adv;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      idx_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign grant_onehot = grant_reg;
  assign grant_valid  = |grant_reg;
  assign grant_idx    = idx_reg;

  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_onehot));

endmodule
